// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo sequencer: FSM states,
// position width/range and the angle-code to position mapping.
package servo_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MOVE,
      SETTLE
   } state_t;

   localparam int POS_W   = 4;
   localparam int POS_MAX = 9;

   // 3*ang computed as 2*ang + ang; the largest code (3) maps to 9
   function automatic logic [POS_W-1:0] ang_to_pos(input logic [1:0] ang);
      return {1'b0, ang, 1'b0} + {2'b00, ang};
   endfunction

endpackage

// File: rtl/servo_if.sv
// Requester/servo bundle: two level requesters with angle codes on one
// side, grants, status, position and the PWM pin on the other.
interface servo_if;
   import servo_pkg::*;

   logic             req_a;
   logic [1:0]       ang_a;
   logic             req_b;
   logic [1:0]       ang_b;
   logic             grant_a;
   logic             grant_b;
   logic             busy;
   logic             done;
   logic [POS_W-1:0] pos;
   logic             Q;

   modport master (
      output req_a, ang_a, req_b, ang_b,
      input  grant_a, grant_b, busy, done, pos, Q
   );

   modport slave (
      input  req_a, ang_a, req_b, ang_b,
      output grant_a, grant_b, busy, done, pos, Q
   );

endinterface

// File: rtl/servo_pwm.sv
// PWM generator: clock divider into slots, slots into frames. The pin is
// high for the first pos slots of each frame; frame_tick marks the last
// clock of a frame so the position may only change between frames.
module servo_pwm
   import servo_pkg::*;
#(
   parameter int CLK_DIV = 1000,
   parameter int FRAME   = 11
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic [POS_W-1:0] pos,
   output logic             Q,
   output logic             frame_tick
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SLOT_W = $clog2(FRAME);

   logic [DIV_W-1:0]  div_reg;
   logic [SLOT_W-1:0] slot_reg;
   logic              div_wrap;
   logic              slot_last;

   assign div_wrap   = (div_reg == DIV_W'(CLK_DIV - 1));
   assign slot_last  = (slot_reg == SLOT_W'(FRAME - 1));
   assign frame_tick = div_wrap && slot_last;

   // Divider and slot counter; the slot advances only when the divider wraps
   always_ff @(posedge CLK) begin
      if (reset) begin
         div_reg  <= '0;
         slot_reg <= '0;
      end else if (div_wrap) begin
         div_reg  <= '0;
         slot_reg <= slot_last ? '0 : slot_reg + SLOT_W'(1);
      end else begin
         div_reg <= div_reg + DIV_W'(1);
      end
   end

   // Compare at a common width so any FRAME size works
   assign Q = (32'(slot_reg) < 32'(pos));

endmodule

// File: rtl/servo_sequencer.sv
// Round-robin arbiter between two angle requesters plus a frame-paced
// ramp FSM that walks the servo position one unit at a time toward the
// granted target, then holds for a settle period before signalling done.
module servo_sequencer
   import servo_pkg::*;
#(
   parameter int CLK_DIV       = 1000,
   parameter int FRAME         = 11,
   parameter int STEP_FRAMES   = 4,
   parameter int SETTLE_FRAMES = 8
) (
   input  logic    CLK,
   input  logic    reset,
   servo_if.slave  bus
);

   localparam int CNT_MAX = (STEP_FRAMES > SETTLE_FRAMES) ? STEP_FRAMES : SETTLE_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t           state_reg, state_next;
   logic [POS_W-1:0] pos_reg, pos_next;
   logic [POS_W-1:0] target_reg, target_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             last_b_reg, last_b_next;
   logic             grant_a_reg, grant_a_next;
   logic             grant_b_reg, grant_b_next;
   logic             done_reg, done_next;
   logic [CNT_W-1:0] cnt_inc;
   logic [POS_W-1:0] pos_step;
   logic             frame_tick;

   servo_pwm #(
      .CLK_DIV (CLK_DIV),
      .FRAME   (FRAME)
   ) u_pwm (
      .CLK        (CLK),
      .reset      (reset),
      .pos        (pos_reg),
      .Q          (bus.Q),
      .frame_tick (frame_tick)
   );

   // Arbitration, ramp stepping and settle timing
   always_comb begin
      state_next   = state_reg;
      pos_next     = pos_reg;
      target_next  = target_reg;
      cnt_next     = cnt_reg;
      last_b_next  = last_b_reg;
      grant_a_next = 1'b0;
      grant_b_next = 1'b0;
      done_next    = 1'b0;
      cnt_inc      = cnt_reg + CNT_W'(1);
      pos_step     = pos_reg;

      if (pos_reg < target_reg) begin
         pos_step = (pos_reg < POS_W'(POS_MAX)) ? pos_reg + POS_W'(1) : pos_reg;
      end else if (pos_reg > target_reg) begin
         pos_step = pos_reg - POS_W'(1);
      end

      case (state_reg)
         IDLE: begin
            // A wins when alone or when B held the previous grant
            if (bus.req_a && (!bus.req_b || last_b_reg)) begin
               grant_a_next = 1'b1;
               last_b_next  = 1'b0;
               target_next  = ang_to_pos(bus.ang_a);
               cnt_next     = '0;
               state_next   = MOVE;
            end else if (bus.req_b) begin
               grant_b_next = 1'b1;
               last_b_next  = 1'b1;
               target_next  = ang_to_pos(bus.ang_b);
               cnt_next     = '0;
               state_next   = MOVE;
            end
         end
         MOVE: begin
            if (frame_tick) begin
               if (pos_reg == target_reg) begin
                  cnt_next   = '0;
                  state_next = SETTLE;
               end else if (int'(cnt_inc) == STEP_FRAMES) begin
                  pos_next = pos_step;
                  cnt_next = '0;
                  if (pos_step == target_reg) begin
                     state_next = SETTLE;
                  end
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         SETTLE: begin
            if (frame_tick) begin
               if (int'(cnt_inc) == SETTLE_FRAMES) begin
                  done_next  = 1'b1;
                  cnt_next   = '0;
                  state_next = IDLE;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register; last-grant starts at B so A wins the first tie
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_reg   <= IDLE;
         pos_reg     <= '0;
         target_reg  <= '0;
         cnt_reg     <= '0;
         last_b_reg  <= 1'b1;
         grant_a_reg <= 1'b0;
         grant_b_reg <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pos_reg     <= pos_next;
         target_reg  <= target_next;
         cnt_reg     <= cnt_next;
         last_b_reg  <= last_b_next;
         grant_a_reg <= grant_a_next;
         grant_b_reg <= grant_b_next;
         done_reg    <= done_next;
      end
   end

   assign bus.grant_a = grant_a_reg;
   assign bus.grant_b = grant_b_reg;
   assign bus.done    = done_reg;
   assign bus.busy    = (state_reg != IDLE);
   assign bus.pos     = pos_reg;

endmodule

// File: tb/tb_servo_sequencer.sv
// Scoreboard bench for servo_sequencer: stimulus queues the expected
// grant/position/done events, a monitor pops them as the DUT shows them,
// and a frame model checks PWM width and in-frame stability.
module tb_servo_sequencer;
   import servo_pkg::*;

   localparam int CLK_DIV       = 2;
   localparam int FRAME         = 11;
   localparam int STEP_FRAMES   = 1;
   localparam int SETTLE_FRAMES = 2;
   localparam int FRAME_CYC     = CLK_DIV * FRAME;
   localparam int DONE_GAP      = SETTLE_FRAMES * FRAME_CYC;

   typedef enum int {EV_GA, EV_GB, EV_POS, EV_DONE} ev_t;
   typedef struct {
      ev_t kind;
      int  val;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   servo_if bus();

   servo_sequencer #(
      .CLK_DIV       (CLK_DIV),
      .FRAME         (FRAME),
      .STEP_FRAMES   (STEP_FRAMES),
      .SETTLE_FRAMES (SETTLE_FRAMES)
   ) dut (
      .CLK   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   checks      = 0;
   int   failures    = 0;
   bit   mon_en      = 1'b0;
   int   cyc         = 0;
   int   abs_cyc     = 0;
   int   prev_pos    = 0;
   int   last_pos_cyc = 0;
   int   pos_frame   = 0;
   int   q_cnt       = 0;
   int   frame_err   = 0;
   int   done_seen   = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push(input ev_t k, input int v);
      exp_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic observe(input ev_t k, input int v);
      exp_t e;
      $display("txn cyc=%0d %s val=%0d", abs_cyc, k.name(), v);
      if (exp_q.size() == 0) begin
         check("unexpected_event", int'(k), -1);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", int'(k), int'(e.kind));
         if (e.kind == EV_POS && k == EV_POS) check("pos_value", v, e.val);
         if (e.kind == EV_DONE && k == EV_DONE && e.val >= 0) check("done_gap", v, e.val);
      end
   endtask

   // Cycle count since reset: tracks the divider/slot position independently
   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

   // Monitor: event scoreboard plus per-frame PWM model
   initial begin
      forever begin
         @(negedge clk);
         abs_cyc++;
         if (mon_en) begin
            int slot;
            int ph;
            if (bus.grant_a) observe(EV_GA, 0);
            if (bus.grant_b) observe(EV_GB, 0);
            if (int'(bus.pos) != prev_pos) begin
               prev_pos     = int'(bus.pos);
               last_pos_cyc = abs_cyc;
               observe(EV_POS, prev_pos);
            end
            if (bus.done) begin
               done_seen++;
               observe(EV_DONE, abs_cyc - last_pos_cyc);
            end
            slot = (cyc / CLK_DIV) % FRAME;
            ph   = cyc % FRAME_CYC;
            if (ph == 0) begin
               pos_frame = int'(bus.pos);
               q_cnt     = 0;
               frame_err = 0;
            end
            if (int'(bus.pos) != pos_frame || bus.Q != (slot < pos_frame)) frame_err++;
            q_cnt += int'(bus.Q);
            if (ph == FRAME_CYC - 1) begin
               check("frame_q_width", q_cnt, CLK_DIV * pos_frame);
               check("frame_stable", frame_err, 0);
            end
         end
      end
   end

   // which: 0 grant_a, 1 grant_b, 2 done, 3 pos==4
   task automatic wait_for(input string name, input int which, input int bound, output int n);
      bit hit;
      hit = 1'b0;
      n   = 0;
      while (!hit && n < bound) begin
         @(negedge clk);
         n++;
         case (which)
            0:       hit = bus.grant_a;
            1:       hit = bus.grant_b;
            2:       hit = bus.done;
            default: hit = (bus.pos == 4'd4);
         endcase
      end
      check({name, "_seen"}, int'(hit), 1);
   endtask

   task automatic request(input bit sel_b, input logic [1:0] ang);
      int n;
      if (sel_b) begin
         bus.ang_b = ang;
         bus.req_b = 1'b1;
         wait_for("grant_b", 1, 10, n);
         check("grant_b_latency", n, 1);
         bus.req_b = 1'b0;
      end else begin
         bus.ang_a = ang;
         bus.req_a = 1'b1;
         wait_for("grant_a", 0, 10, n);
         check("grant_a_latency", n, 1);
         bus.req_a = 1'b0;
      end
      check("busy_at_grant", int'(bus.busy), 1);
   endtask

   task automatic wait_done();
      int n;
      wait_for("done", 2, 600, n);
      check("busy_at_done", int'(bus.busy), 0);
   endtask

   // Directed stimulus
   initial begin
      int n;
      int ds;
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
      bus.ang_a = 2'd0;
      bus.ang_b = 2'd0;
      reset     = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_pos", int'(bus.pos), 0);
      check("rst_q", int'(bus.Q), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_grant_a", int'(bus.grant_a), 0);
      check("rst_grant_b", int'(bus.grant_b), 0);
      check("rst_done", int'(bus.done), 0);
      mon_en = 1'b1;
      reset  = 1'b0;
      repeat (2 * FRAME_CYC) @(negedge clk);

      // Single request A, code 2 -> ramp 0..6
      push(EV_GA, 0);
      for (int p = 1; p <= 6; p++) push(EV_POS, p);
      push(EV_DONE, DONE_GAP);
      request(1'b0, 2'd2);
      wait_done();
      repeat (2 * FRAME_CYC) @(negedge clk);
      check("pos_after_single", int'(bus.pos), 6);
      check("queue_single", exp_q.size(), 0);

      // Tie from reset: A (target 3) first, B (target 9) right after done
      push(EV_POS, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      push(EV_GA, 0);
      for (int p = 1; p <= 3; p++) push(EV_POS, p);
      push(EV_DONE, DONE_GAP);
      push(EV_GB, 0);
      for (int p = 4; p <= 9; p++) push(EV_POS, p);
      push(EV_DONE, DONE_GAP);
      bus.ang_b = 2'd3;
      bus.req_b = 1'b1;
      request(1'b0, 2'd1);
      wait_done();
      check("grant_b_on_done", int'(bus.grant_b), 0);
      @(negedge clk);
      check("grant_b_after_done", int'(bus.grant_b), 1);
      bus.req_b = 1'b0;
      wait_done();
      check("pos_after_tie", int'(bus.pos), 9);

      // Down to 6, then B asks for the same position
      push(EV_GA, 0);
      for (int p = 8; p >= 6; p--) push(EV_POS, p);
      push(EV_DONE, DONE_GAP);
      request(1'b0, 2'd2);
      wait_done();
      push(EV_GB, 0);
      push(EV_DONE, -1);
      request(1'b1, 2'd2);
      wait_done();
      check("pos_same_target", int'(bus.pos), 6);

      // Up to 9, then full downward sweep to 0
      push(EV_GA, 0);
      for (int p = 7; p <= 9; p++) push(EV_POS, p);
      push(EV_DONE, DONE_GAP);
      request(1'b0, 2'd3);
      wait_done();
      push(EV_GB, 0);
      for (int p = 8; p >= 0; p--) push(EV_POS, p);
      push(EV_DONE, DONE_GAP);
      request(1'b1, 2'd0);
      wait_done();
      check("pos_after_down", int'(bus.pos), 0);
      repeat (FRAME_CYC) @(negedge clk);

      // Reset in the middle of a ramp at pos 4
      push(EV_GA, 0);
      for (int p = 1; p <= 4; p++) push(EV_POS, p);
      request(1'b0, 2'd3);
      wait_for("pos4", 3, 400, n);
      push(EV_POS, 0);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_pos", int'(bus.pos), 0);
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_q", int'(bus.Q), 0);
      check("midrst_done", int'(bus.done), 0);
      @(negedge clk);
      reset = 1'b0;
      ds = done_seen;
      repeat (3 * FRAME_CYC) @(negedge clk);
      check("no_done_after_reset", done_seen - ds, 0);
      check("busy_after_reset", int'(bus.busy), 0);

      repeat (5) @(negedge clk);
      check("queue_end", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
